// File: rtl/rc4_engine.sv
// rc4_engine: RC4 sequencer running S-box init, key schedule and keystream decrypt in one FSM.
// Optional feature macro: ASCII_CHECK_EN (abort on a plaintext byte outside 0x20..0x7E, flag key_fail).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   start, secret_key               run request, key (byte 0 in the MSBs), key latched on accept
//   busy, done, key_fail            run status; key_fail only with ASCII_CHECK_EN
//   s_mem_addr/data_in/data_out/write   256x8 S RAM, 1-cycle registered read
//   d_mem_addr/data_in/write            MSG_LEN x8 plaintext RAM
//   e_mem_addr/data_out                 MSG_LEN x8 ciphertext ROM, 1-cycle registered read
module rc4_engine #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32,
    parameter int MSG_AW    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    output logic                   key_fail,
    output logic [7:0]             s_mem_addr,
    output logic [7:0]             s_mem_data_in,
    input  logic [7:0]             s_mem_data_out,
    output logic                   s_mem_write,
    output logic [MSG_AW-1:0]      d_mem_addr,
    output logic [7:0]             d_mem_data_in,
    output logic                   d_mem_write,
    output logic [MSG_AW-1:0]      e_mem_addr,
    input  logic [7:0]             e_mem_data_out
);
    localparam int KB_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, DONE} state_t;
    state_t state;
    logic [3:0] step;
    logic [7:0] i, j, si, sj;
    logic [MSG_AW-1:0] k;
    logic [KB_W-1:0] kb;
    logic [7:0] key_b [KEY_BYTES];
    logic [7:0] j_ksa, j_prga, pt;
    // j is computed from the freshly returned S[i] so the S[j] read issues in the same cycle
    always_comb begin
        j_ksa  = j + s_mem_data_out + key_b[kb];
        j_prga = j + s_mem_data_out;
        pt     = s_mem_data_out ^ e_mem_data_out;
    end
`ifdef ASCII_CHECK_EN
    logic pt_ok;
    always_comb pt_ok = (pt >= 8'h20) && (pt <= 8'h7e);
`else
    assign key_fail = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            step          <= '0;
            i             <= '0;
            j             <= '0;
            k             <= '0;
            si            <= '0;
            sj            <= '0;
            kb            <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef ASCII_CHECK_EN
            key_fail      <= 1'b0;
`endif
            s_mem_addr    <= '0;
            s_mem_data_in <= '0;
            s_mem_write   <= 1'b0;
            d_mem_addr    <= '0;
            d_mem_data_in <= '0;
            d_mem_write   <= 1'b0;
            e_mem_addr    <= '0;
        end else begin
            s_mem_write <= 1'b0;
            d_mem_write <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    if (start) begin
                        state <= INIT;
                        i     <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
`ifdef ASCII_CHECK_EN
                        key_fail <= 1'b0;
`endif
                        for (int b = 0; b < KEY_BYTES; b++)
                            key_b[b] <= secret_key[8*(KEY_BYTES-1-b) +: 8];
                    end
                end
                INIT: begin
                    s_mem_addr    <= i;
                    s_mem_data_in <= i;
                    s_mem_write   <= 1'b1;
                    i             <= i + 8'd1;
                    if (i == 8'hff) begin
                        state <= KSA;
                        step  <= '0;
                        j     <= '0;
                        kb    <= '0;
                    end
                end
                KSA: begin
                    step <= step + 4'd1;
                    case (step)
                        4'd0: s_mem_addr <= i;
                        4'd2: begin
                            si         <= s_mem_data_out;
                            j          <= j_ksa;
                            s_mem_addr <= j_ksa;
                        end
                        4'd4: begin
                            s_mem_addr    <= i;
                            s_mem_data_in <= s_mem_data_out;
                            s_mem_write   <= 1'b1;
                        end
                        4'd5: begin
                            s_mem_addr    <= j;
                            s_mem_data_in <= si;
                            s_mem_write   <= 1'b1;
                            step          <= '0;
                            i             <= i + 8'd1;
                            kb            <= (kb == KB_W'(KEY_BYTES - 1)) ? '0 : kb + KB_W'(1);
                            if (i == 8'hff) begin
                                state <= PRGA;
                                j     <= '0;
                                k     <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
                PRGA: begin
                    step <= step + 4'd1;
                    case (step)
                        4'd0: begin
                            i          <= i + 8'd1;
                            s_mem_addr <= i + 8'd1;
                        end
                        4'd2: begin
                            si         <= s_mem_data_out;
                            j          <= j_prga;
                            s_mem_addr <= j_prga;
                        end
                        4'd4: begin
                            sj            <= s_mem_data_out;
                            s_mem_addr    <= i;
                            s_mem_data_in <= s_mem_data_out;
                            s_mem_write   <= 1'b1;
                        end
                        4'd5: begin
                            s_mem_addr    <= j;
                            s_mem_data_in <= si;
                            s_mem_write   <= 1'b1;
                        end
                        4'd6: begin
                            s_mem_addr <= si + sj;
                            e_mem_addr <= k;
                        end
                        4'd8: begin
                            step          <= '0;
                            k             <= k + MSG_AW'(1);
                            d_mem_addr    <= k;
                            d_mem_data_in <= pt;
`ifdef ASCII_CHECK_EN
                            if (!pt_ok) begin
                                state    <= DONE;
                                key_fail <= 1'b1;
                            end else begin
                                d_mem_write <= 1'b1;
                                if (k == MSG_AW'(MSG_LEN - 1)) state <= DONE;
                            end
`else
                            d_mem_write <= 1'b1;
                            if (k == MSG_AW'(MSG_LEN - 1)) state <= DONE;
`endif
                        end
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
